// File: rtl/predictor_scoreboard_if.sv
// Sample/score bundle between a predictor source and predictor_scoreboard.
// The master drives the sample fields; the slave returns the chooser and window statistics.
interface predictor_scoreboard_if;
    logic       valid;
    logic       actual_pattern;
    logic       pred_a;
    logic       pred_b;
    logic       clear;
    logic       chosen_pred;
    logic [1:0] sel_state;
    logic [7:0] win_hits_a;
    logic [7:0] win_hits_b;
    logic [7:0] win_hits_chosen;
    logic       window_done;
    logic [3:0] miss_streak;
    logic       alarm;

    modport master (
        output valid, actual_pattern, pred_a, pred_b, clear,
        input  chosen_pred, sel_state, win_hits_a, win_hits_b, win_hits_chosen,
        input  window_done, miss_streak, alarm
    );

    modport slave (
        input  valid, actual_pattern, pred_a, pred_b, clear,
        output chosen_pred, sel_state, win_hits_a, win_hits_b, win_hits_chosen,
        output window_done, miss_streak, alarm
    );
endinterface

// File: rtl/predictor_scoreboard.sv
// Tournament chooser between two 1-bit predictors with windowed hit statistics
// and a consecutive-miss alarm on the chosen prediction.
module predictor_scoreboard #(
    parameter int unsigned WINDOW     = 16,
    parameter int unsigned MISS_LIMIT = 4
) (
    input logic                   clk,
    input logic                   reset,
    predictor_scoreboard_if.slave bus
);
    typedef enum logic [1:0] {
        StStrongA = 2'b00,
        StWeakA   = 2'b01,
        StWeakB   = 2'b10,
        StStrongB = 2'b11
    } chooser_e;

    localparam logic [7:0] LastCnt  = 8'(WINDOW - 1);
    localparam logic [3:0] AlarmCnt = 4'(MISS_LIMIT);

    chooser_e   state_q, state_d;
    logic       chosen_pred;
    logic       hit_a, hit_b, hit_c;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d, acc_c_q, acc_c_d;
    logic [7:0] win_a_q, win_a_d, win_b_q, win_b_d, win_c_q, win_c_d;
    logic       done_q, done_d;
    logic [3:0] streak_q, streak_d;

    // Chooser state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWeakA;
        end else begin
            state_q <= state_d;
        end
    end

    // Chooser next state: move toward whichever predictor alone was right
    always_comb begin
        state_d = state_q;
        if (bus.valid && hit_a && !hit_b) begin
            unique case (state_q)
                StStrongA: state_d = StStrongA;
                StWeakA:   state_d = StStrongA;
                StWeakB:   state_d = StWeakA;
                StStrongB: state_d = StWeakB;
                default:   state_d = state_q;
            endcase
        end else if (bus.valid && hit_b && !hit_a) begin
            unique case (state_q)
                StStrongA: state_d = StWeakA;
                StWeakA:   state_d = StWeakB;
                StWeakB:   state_d = StStrongB;
                StStrongB: state_d = StStrongB;
                default:   state_d = state_q;
            endcase
        end
    end

    // Chooser output uses the pre-update state
    always_comb begin
        chosen_pred = bus.pred_a;
        if (state_q[1]) begin
            chosen_pred = bus.pred_b;
        end
    end

    assign hit_a = ~(bus.pred_a ^ bus.actual_pattern);
    assign hit_b = ~(bus.pred_b ^ bus.actual_pattern);
    assign hit_c = ~(chosen_pred ^ bus.actual_pattern);

    // Window statistics; clear drops the coincident sample, including a window-final one
    always_comb begin
        cnt_d    = cnt_q;
        acc_a_d  = acc_a_q;
        acc_b_d  = acc_b_q;
        acc_c_d  = acc_c_q;
        win_a_d  = win_a_q;
        win_b_d  = win_b_q;
        win_c_d  = win_c_q;
        done_d   = 1'b0;
        streak_d = streak_q;
        if (bus.clear) begin
            cnt_d    = '0;
            acc_a_d  = '0;
            acc_b_d  = '0;
            acc_c_d  = '0;
            win_a_d  = '0;
            win_b_d  = '0;
            win_c_d  = '0;
            streak_d = '0;
        end else if (bus.valid) begin
            if (cnt_q == LastCnt) begin
                win_a_d = acc_a_q + 8'(hit_a);
                win_b_d = acc_b_q + 8'(hit_b);
                win_c_d = acc_c_q + 8'(hit_c);
                cnt_d   = '0;
                acc_a_d = '0;
                acc_b_d = '0;
                acc_c_d = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d   = cnt_q + 8'd1;
                acc_a_d = acc_a_q + 8'(hit_a);
                acc_b_d = acc_b_q + 8'(hit_b);
                acc_c_d = acc_c_q + 8'(hit_c);
            end
            if (hit_c) begin
                streak_d = '0;
            end else if (streak_q != 4'hF) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            acc_c_q  <= '0;
            win_a_q  <= '0;
            win_b_q  <= '0;
            win_c_q  <= '0;
            done_q   <= 1'b0;
            streak_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_a_q  <= acc_a_d;
            acc_b_q  <= acc_b_d;
            acc_c_q  <= acc_c_d;
            win_a_q  <= win_a_d;
            win_b_q  <= win_b_d;
            win_c_q  <= win_c_d;
            done_q   <= done_d;
            streak_q <= streak_d;
        end
    end

    assign bus.chosen_pred     = chosen_pred;
    assign bus.sel_state       = state_q;
    assign bus.win_hits_a      = win_a_q;
    assign bus.win_hits_b      = win_b_q;
    assign bus.win_hits_chosen = win_c_q;
    assign bus.window_done     = done_q;
    assign bus.miss_streak     = streak_q;
    assign bus.alarm           = (streak_q >= AlarmCnt);
endmodule

// File: tb/tb_predictor_scoreboard.sv
// Scoreboard bench for predictor_scoreboard: stimulus pushes expected outputs from a
// behavioural model; a negedge monitor pops and compares them.
module tb_predictor_scoreboard;
    localparam int WINDOW     = 16;
    localparam int MISS_LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    predictor_scoreboard_if bus ();

    predictor_scoreboard #(
        .WINDOW    (WINDOW),
        .MISS_LIMIT(MISS_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic       chosen;
        logic [1:0] sel;
        logic [7:0] wa;
        logic [7:0] wb;
        logic [7:0] wc;
        logic       done;
        logic [3:0] streak;
        logic       alarm;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] win_q[$];
    logic [2:0]  samp_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: chooser level 0..3, window sample list, last window, miss streak
    int m_sel    = 1;
    int m_wa     = 0;
    int m_wb     = 0;
    int m_wc     = 0;
    bit m_done   = 0;
    int m_streak = 0;
    bit m_known  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic step(input bit v, input bit act, input bit pa, input bit pb,
                        input bit clr, input bit rst);
        exp_t e;
        bit ch, ha, hb, hc;
        int sa, sb, sc;
        @(posedge clk);
        #1;
        bus.valid          = v;
        bus.actual_pattern = act;
        bus.pred_a         = pa;
        bus.pred_b         = pb;
        bus.clear          = clr;
        reset              = rst;
        ch = (m_sel >= 2) ? pb : pa;
        if (m_known) begin
            e.chosen = ch;
            e.sel    = 2'(m_sel);
            e.wa     = 8'(m_wa);
            e.wb     = 8'(m_wb);
            e.wc     = 8'(m_wc);
            e.done   = m_done;
            e.streak = 4'(m_streak);
            e.alarm  = (m_streak >= MISS_LIMIT);
            exp_q.push_back(e);
        end
        ha = (pa == act);
        hb = (pb == act);
        hc = (ch == act);
        if (rst) begin
            m_known  = 1;
            m_sel    = 1;
            samp_q.delete();
            m_wa     = 0;
            m_wb     = 0;
            m_wc     = 0;
            m_done   = 0;
            m_streak = 0;
        end else begin
            m_done = 0;
            if (v && ha && !hb && m_sel > 0) m_sel--;
            if (v && hb && !ha && m_sel < 3) m_sel++;
            if (clr) begin
                samp_q.delete();
                m_wa     = 0;
                m_wb     = 0;
                m_wc     = 0;
                m_streak = 0;
            end else if (v) begin
                samp_q.push_back({ha, hb, hc});
                if (samp_q.size() == WINDOW) begin
                    sa = 0;
                    sb = 0;
                    sc = 0;
                    foreach (samp_q[i]) begin
                        sa += int'(samp_q[i][2]);
                        sb += int'(samp_q[i][1]);
                        sc += int'(samp_q[i][0]);
                    end
                    m_wa   = sa;
                    m_wb   = sb;
                    m_wc   = sc;
                    m_done = 1;
                    win_q.push_back({8'(sa), 8'(sb), 8'(sc)});
                    samp_q.delete();
                end
                m_streak = hc ? 0 : ((m_streak < 15) ? m_streak + 1 : 15);
            end
        end
    endtask

    // mode 0: A right/B wrong, 1: A wrong/B right, 2: both wrong, 3: both right, 4: random
    task automatic pat(input int n, input int mode, input bit clr_last);
        bit act, pa, pb, clr;
        for (int i = 0; i < n; i++) begin
            act = 1'($urandom_range(0, 1));
            case (mode)
                0:       begin pa = act;  pb = ~act; end
                1:       begin pa = ~act; pb = act;  end
                2:       begin pa = ~act; pb = ~act; end
                3:       begin pa = act;  pb = act;  end
                default: begin pa = 1'($urandom_range(0, 1)); pb = 1'($urandom_range(0, 1)); end
            endcase
            clr = clr_last && (i == n - 1);
            step(1'b1, act, pa, pb, clr, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    exp_t        mon_e;
    logic [23:0] mon_w;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("chosen_pred",     32'(bus.chosen_pred),     32'(mon_e.chosen));
            chk("sel_state",       32'(bus.sel_state),       32'(mon_e.sel));
            chk("win_hits_a",      32'(bus.win_hits_a),      32'(mon_e.wa));
            chk("win_hits_b",      32'(bus.win_hits_b),      32'(mon_e.wb));
            chk("win_hits_chosen", 32'(bus.win_hits_chosen), 32'(mon_e.wc));
            chk("window_done",     32'(bus.window_done),     32'(mon_e.done));
            chk("miss_streak",     32'(bus.miss_streak),     32'(mon_e.streak));
            chk("alarm",           32'(bus.alarm),           32'(mon_e.alarm));
        end
        if (bus.window_done === 1'b1) begin
            if (win_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL window_unexpected at %0t: got window_done=1 expected 0", $time);
            end else begin
                mon_w = win_q.pop_front();
                chk("window_a", 32'(bus.win_hits_a),      32'(mon_w[23:16]));
                chk("window_b", 32'(bus.win_hits_b),      32'(mon_w[15:8]));
                chk("window_c", 32'(bus.win_hits_chosen), 32'(mon_w[7:0]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit act, pa, pb, v, clr, rst;
        reset              = 1'b1;
        bus.valid          = 1'b0;
        bus.actual_pattern = 1'b0;
        bus.pred_a         = 1'b0;
        bus.pred_b         = 1'b0;
        bus.clear          = 1'b0;

        do_reset();
        do_reset();
        // A always right: STRONG_A, full window of 16/0/16
        pat(WINDOW, 0, 1'b0);
        idle(2);
        // From WEAK_A, B always right
        do_reset();
        pat(3, 1, 1'b0);
        // Misses separated by idle cycles, then a hit
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pat(1, 2, 1'b0);
            idle(2);
        end
        pat(1, 3, 1'b0);
        idle(1);
        // Saturating miss streak
        pat(20, 2, 1'b0);
        pat(1, 3, 1'b0);
        // clear on the window-final sample, chooser still moves
        do_reset();
        pat(WINDOW - 1, 4, 1'b0);
        pat(1, 1, 1'b1);
        pat(WINDOW, 4, 1'b0);
        idle(2);
        // reset mid-window
        do_reset();
        pat(10, 4, 1'b0);
        do_reset();
        pat(WINDOW - 1, 4, 1'b0);
        idle(1);
        pat(1, 4, 1'b0);
        idle(2);
        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            act = 1'($urandom_range(0, 1));
            pa  = ($urandom_range(0, 3) != 0) ? act : ~act;
            pb  = ($urandom_range(0, 1) != 0) ? act : ~act;
            clr = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step(v, act, pa, pb, clr, rst);
        end
        idle(3);
        @(negedge clk);
        #1;
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        chk("win_drained", 32'(win_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/predictor_scoreboard.md
PREDICTOR_SCOREBOARD -- requirements
Module: predictor_scoreboard

Interface
REQ-001 Parameter WINDOW, default 16, SHALL set the number of valid samples per scoring window (legal range 2..255).
REQ-002 Parameter MISS_LIMIT, default 4, SHALL set the consecutive-miss count that raises alarm (legal range 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 valid  input  1  SHALL qualify one scoring sample per cycle when high.
REQ-006 actual_pattern  input  1  SHALL carry the resolved outcome bit of the current sample.
REQ-007 pred_a  input  1  SHALL carry predictor A's prediction for the current sample.
REQ-008 pred_b  input  1  SHALL carry predictor B's prediction for the current sample.
REQ-009 clear  input  1  SHALL synchronously clear window statistics without touching the chooser.
REQ-010 chosen_pred  output  1  SHALL be the tournament-selected prediction (combinational).
REQ-011 sel_state  output  2  SHALL expose the chooser state.
REQ-012 win_hits_a, win_hits_b, win_hits_chosen  output  8 each  SHALL hold the hit counts of the last completed window.
REQ-013 window_done  output  1  SHALL pulse for one cycle when a window completes.
REQ-014 miss_streak  output  4  SHALL count consecutive chosen-prediction misses.
REQ-015 alarm  output  1  SHALL be high while miss_streak >= MISS_LIMIT.

Function
REQ-016 Sample hit definitions SHALL be: hit_a = pred_a XNOR actual_pattern; hit_b = pred_b XNOR actual_pattern; hit_c = chosen_pred XNOR actual_pattern.
REQ-017 Chooser SHALL be a 2-bit saturating FSM with states STRONG_A=00, WEAK_A=01, WEAK_B=10, STRONG_B=11.
REQ-018 chosen_pred SHALL equal pred_a when sel_state[1]=0, else pred_b, using the pre-update state of the same cycle.
REQ-019 On a valid sample with hit_a=1, hit_b=0, the chooser SHALL decrement, saturating at STRONG_A.
REQ-020 On a valid sample with hit_a=0, hit_b=1, the chooser SHALL increment, saturating at STRONG_B.
REQ-021 On a valid sample with hit_a equal to hit_b, and on any cycle with valid=0, the chooser SHALL hold.
REQ-022 Internal sample_cnt (8 bits, 0..WINDOW-1) and running hit counters acc_a, acc_b, acc_c (8 bits) SHALL increment on valid samples (accumulators only on the matching hit).
REQ-023 On the valid sample where sample_cnt = WINDOW-1, the next edge SHALL load win_hits_* with the running counts including that sample, clear sample_cnt and acc_*, and assert window_done for exactly the following cycle.
REQ-024 win_hits_* SHALL hold their value until the next window completes, clear, or reset.
REQ-025 miss_streak SHALL increment on a valid sample with hit_c=0, saturating at 15, and clear to 0 on a valid sample with hit_c=1; it SHALL hold when valid=0.
REQ-026 alarm SHALL be registered-equivalent: derived combinationally from the registered miss_streak.
REQ-027 clear=1 SHALL, at the next edge, zero sample_cnt, acc_*, win_hits_*, miss_streak and window_done; a coincident valid sample SHALL be dropped for statistics but SHALL still update the chooser.
REQ-028 clear coinciding with the window-final sample SHALL win: no window_done pulse and win_hits_* = 0.
REQ-029 Latency: counters, miss_streak and sel_state SHALL reflect a sample one cycle after it is presented; chosen_pred SHALL have zero latency.

Reset
REQ-030 reset=1 at a rising edge SHALL set sel_state=WEAK_A, sample_cnt=0, acc_*=0, win_hits_*=0, window_done=0, miss_streak=0 (hence alarm=0).
REQ-031 reset SHALL take priority over clear and valid; reset mid-window SHALL discard the partial window with no window_done pulse.
REQ-032 Outputs SHALL be defined (no X) from the first edge after reset.

Verification
REQ-033 Reset, then 16 valid samples with pred_a=actual, pred_b=~actual -> sel_state reaches STRONG_A after 1 sample and stays; window_done pulses once on cycle 17; win_hits_a=16, win_hits_b=0, win_hits_chosen=16.
REQ-034 From WEAK_A, 3 samples pred_a wrong/pred_b right -> sel_state 10, 11, 11; chosen_pred switches to pred_b starting at the 2nd sample.
REQ-035 Chosen prediction wrong on 5 consecutive valid samples with idle cycles between -> miss_streak 1..5, alarm rises after the 4th, one correct sample -> miss_streak=0, alarm=0.
REQ-036 20 consecutive misses -> miss_streak saturates at 15, no wrap.
REQ-037 clear asserted together with the 16th valid sample of a window -> no window_done, win_hits_*=0, sample_cnt restarts at 0; sel_state still updated by that sample.
REQ-038 reset asserted after 10 samples of a window -> all outputs return to REQ-030 values the next cycle; the next window requires a full 16 samples.
